// File: rtl/operand_issue_queue.sv
// Operand issue queue: buffers {A, B, opcode} triples in a small circular FIFO,
// issues at most one per clock to the datapath and flags each result LAT clocks later.
module operand_issue_queue #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_A,
    input  logic [N-1:0]             in_B,
    input  logic [2:0]               in_opcode,
    input  logic                     issue_en,
    output logic [N-1:0]             A,
    output logic [N-1:0]             B,
    output logic [2:0]               opcode,
    output logic                     issue_valid,
    output logic [3:0]               issue_tag,
    output logic                     res_valid,
    output logic [3:0]               res_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    seq_q, seq_d;

    entry_t        out_q, out_d;
    logic          issue_valid_q, issue_valid_d;
    logic [3:0]    issue_tag_q, issue_tag_d;

    logic [LAT-1:0] trk_valid_q, trk_valid_d;
    logic [3:0]     trk_tag_q [LAT];
    logic [3:0]     trk_tag_d [LAT];

    logic push;
    logic pop;

    // Ready comes from the registered count only, so a same-cycle pop never frees a full slot.
    assign in_ready = (count_q != FULL_COUNT);
    assign push     = in_valid && in_ready;
    assign pop      = issue_en && (count_q != '0);

    // NOTE: every signal gets a default before the conditionals, so no path leaves it unassigned and no latch is inferred.
    always_comb begin : fifo_next
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: in_A, b: in_B, op: in_opcode};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Operand registers only load on a pop so the datapath inputs stay quiet while stalled.
    always_comb begin : issue_next
        out_d         = out_q;
        issue_valid_d = pop;
        issue_tag_d   = issue_tag_q;
        seq_d         = seq_q;
        if (pop) begin
            out_d       = mem_q[rd_ptr_q];
            issue_tag_d = seq_q;
            seq_d       = seq_q + 4'd1;
        end
    end

    // The tracker never stalls: it mirrors the datapath pipeline, which always advances.
    always_comb begin : tracker_next
        trk_valid_d    = '0;
        trk_valid_d[0] = issue_valid_q;
        trk_tag_d[0]   = issue_tag_q;
        for (int i = 1; i < LAT; i++) begin
            trk_valid_d[i] = trk_valid_q[i-1];
            trk_tag_d[i]   = trk_tag_q[i-1];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin : state_regs
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            seq_q         <= '0;
            out_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_tag_q   <= '0;
            trk_valid_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                trk_tag_q[i] <= '0;
            end
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            seq_q         <= seq_d;
            out_q         <= out_d;
            issue_valid_q <= issue_valid_d;
            issue_tag_q   <= issue_tag_d;
            trk_valid_q   <= trk_valid_d;
            for (int i = 0; i < LAT; i++) begin
                trk_tag_q[i] <= trk_tag_d[i];
            end
        end
    end

    // NOTE: FIFO storage has no reset; count_q guarantees a slot is written before it is read.
    always_ff @(posedge clk) begin : storage
        mem_q <= mem_d;
    end

    assign A           = out_q.a;
    assign B           = out_q.b;
    assign opcode      = out_q.op;
    assign issue_valid = issue_valid_q;
    assign issue_tag   = issue_tag_q;
    assign res_valid   = trk_valid_q[LAT-1];
    assign res_tag     = trk_tag_q[LAT-1];
    assign count       = count_q;

endmodule
